// File: rtl/dm_tap.sv
// dm_tap: JTAG TAP controller running entirely in the system clock domain.
//
// The JTAG pins are oversampled on clk. Each pin passes through a SyncStages-deep
// synchronizer, and tck edges are detected from the synchronized copy. The IEEE
// 1149.1 TAP state machine advances once per detected tck rise. The block holds
// the IR, IDCODE and BYPASS registers. It also produces the capture/shift/update
// strobes and the select lines used by the downstream DTM shift registers.
//
// Ports
//   clk            system clock; all state changes on the rising edge
//   reset          synchronous reset, active low
//   tck_i, tms_i, tdi_i, trst_i   raw JTAG pins (trst_i is active low)
//   dmi_tdo_i      serial-out bit of the DTM DMI register
//   dtmcs_tdo_i    serial-out bit of the DTM dtmcs register
//   tdo_o          JTAG TDO pin, updated on tck fall
//   tdo_oe_o       TDO output enable, high while shifting IR or DR
//   tdi_o          synchronized TDI, valid while shift_o is high
//   capture_o, shift_o, update_o   one-clk strobes for CaptureDr/ShiftDr/UpdateDr
//   dmi_select_o   IR holds DMIACCESS
//   dtmcs_select_o IR holds DTMCS
//   dmi_clear_o    one-clk pulse on entry to TestLogicReset
module dm_tap #(
    parameter int unsigned IrLength    = 5,
    parameter logic [31:0] IdcodeValue = 32'h00000001,
    parameter int unsigned SyncStages  = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic tck_i,
    input  logic tms_i,
    input  logic tdi_i,
    input  logic trst_i,
    input  logic dmi_tdo_i,
    input  logic dtmcs_tdo_i,
    output logic tdo_o,
    output logic tdo_oe_o,
    output logic tdi_o,
    output logic capture_o,
    output logic shift_o,
    output logic update_o,
    output logic dmi_select_o,
    output logic dtmcs_select_o,
    output logic dmi_clear_o
);

    localparam logic [IrLength-1:0] IrIdcode    = IrLength'(5'h01);
    localparam logic [IrLength-1:0] IrDtmcs     = IrLength'(5'h10);
    localparam logic [IrLength-1:0] IrDmiAccess = IrLength'(5'h11);
    localparam logic [IrLength-1:0] IrCapture   = IrLength'(5'b00101);

    typedef enum logic [3:0] {
        TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr,
        ShiftDr, Exit1Dr, PauseDr, Exit2Dr,
        UpdateDr, SelectIrScan, CaptureIr, ShiftIr,
        Exit1Ir, PauseIr, Exit2Ir, UpdateIr
    } tap_state_e;

    // ---- pin synchronizers ----
    logic [SyncStages-1:0] tck_sync, tms_sync, tdi_sync, trst_sync;
    logic tck_prev;

    always_ff @(posedge clk) begin
        tck_sync  <= {tck_sync[SyncStages-2:0], tck_i};
        tms_sync  <= {tms_sync[SyncStages-2:0], tms_i};
        tdi_sync  <= {tdi_sync[SyncStages-2:0], tdi_i};
        trst_sync <= {trst_sync[SyncStages-2:0], trst_i};
        tck_prev  <= tck_sync[SyncStages-1];
    end

    logic tck_s, tms_s, tdi_s, trst_s;
    logic tck_rise, tck_fall, tap_rst;

    assign tck_s    = tck_sync[SyncStages-1];
    assign tms_s    = tms_sync[SyncStages-1];
    assign tdi_s    = tdi_sync[SyncStages-1];
    assign trst_s   = trst_sync[SyncStages-1];
    assign tck_rise = tck_s & ~tck_prev;
    assign tck_fall = ~tck_s & tck_prev;
    // Either reset source wins over a coincident tck edge.
    assign tap_rst  = ~reset | ~trst_s;

    // ---- TAP state machine ----
    tap_state_e state_q, state_d;
    logic       rst_q;
    logic       dmi_clear_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            TestLogicReset: state_d = tms_s ? TestLogicReset : RunTestIdle;
            RunTestIdle:    state_d = tms_s ? SelectDrScan   : RunTestIdle;
            SelectDrScan:   state_d = tms_s ? SelectIrScan   : CaptureDr;
            CaptureDr:      state_d = tms_s ? Exit1Dr        : ShiftDr;
            ShiftDr:        state_d = tms_s ? Exit1Dr        : ShiftDr;
            Exit1Dr:        state_d = tms_s ? UpdateDr       : PauseDr;
            PauseDr:        state_d = tms_s ? Exit2Dr        : PauseDr;
            Exit2Dr:        state_d = tms_s ? UpdateDr       : ShiftDr;
            UpdateDr:       state_d = tms_s ? SelectDrScan   : RunTestIdle;
            SelectIrScan:   state_d = tms_s ? TestLogicReset : CaptureIr;
            CaptureIr:      state_d = tms_s ? Exit1Ir        : ShiftIr;
            ShiftIr:        state_d = tms_s ? Exit1Ir        : ShiftIr;
            Exit1Ir:        state_d = tms_s ? UpdateIr       : PauseIr;
            PauseIr:        state_d = tms_s ? Exit2Ir        : PauseIr;
            Exit2Ir:        state_d = tms_s ? UpdateIr       : ShiftIr;
            UpdateIr:       state_d = tms_s ? SelectDrScan   : RunTestIdle;
            default:        state_d = TestLogicReset;
        endcase
    end

    // rst_q remembers that the previous cycle was in reset.
    // This lets dmi_clear fire once when the reset is released.
    always_ff @(posedge clk) begin
        if (tap_rst) begin
            state_q     <= TestLogicReset;
            rst_q       <= 1'b1;
            dmi_clear_q <= 1'b0;
        end else begin
            rst_q       <= 1'b0;
            dmi_clear_q <= rst_q | (tck_rise && state_q != TestLogicReset
                                             && state_d == TestLogicReset);
            if (tck_rise) state_q <= state_d;
        end
    end

    // ---- IR, IDCODE, BYPASS and TDO ----
    logic [IrLength-1:0] ir_q, ir_sr;
    logic [31:0]         idcode_sr;
    logic                bypass_q;
    logic                tdo_q, tdo_oe_q;
    logic                dr_tdo;

    always_comb begin
        dr_tdo = bypass_q;
        case (ir_q)
            IrIdcode:    dr_tdo = idcode_sr[0];
            IrDtmcs:     dr_tdo = dtmcs_tdo_i;
            IrDmiAccess: dr_tdo = dmi_tdo_i;
            default:     dr_tdo = bypass_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tap_rst) begin
            ir_q      <= IrIdcode;
            ir_sr     <= '0;
            idcode_sr <= '0;
            bypass_q  <= 1'b0;
            tdo_q     <= 1'b0;
            tdo_oe_q  <= 1'b0;
        end else begin
            if (tck_rise) begin
                case (state_q)
                    CaptureIr: ir_sr <= IrCapture;
                    ShiftIr:   ir_sr <= {tdi_s, ir_sr[IrLength-1:1]};
                    UpdateIr:  ir_q  <= ir_sr;
                    CaptureDr: begin
                        if (ir_q == IrIdcode) idcode_sr <= IdcodeValue;
                        bypass_q <= 1'b0;
                    end
                    ShiftDr: begin
                        idcode_sr <= {tdi_s, idcode_sr[31:1]};
                        bypass_q  <= tdi_s;
                    end
                    default: ;
                endcase
            end
            // TestLogicReset holds the IR at IDCODE, not only on entry.
            if (state_q == TestLogicReset) ir_q <= IrIdcode;
            // TDO changes on tck fall so the host samples it stable on the next rise.
            if (tck_fall) begin
                tdo_q    <= 1'b0;
                tdo_oe_q <= 1'b0;
                if (state_q == ShiftIr) begin
                    tdo_q    <= ir_sr[0];
                    tdo_oe_q <= 1'b1;
                end else if (state_q == ShiftDr) begin
                    tdo_q    <= dr_tdo;
                    tdo_oe_q <= 1'b1;
                end
            end
        end
    end

    // The strobes cover the clk cycle of the tck rise.
    // They are decoded from the state being left.
    assign capture_o      = tck_rise & ~tap_rst & (state_q == CaptureDr);
    assign shift_o        = tck_rise & ~tap_rst & (state_q == ShiftDr);
    assign update_o       = tck_rise & ~tap_rst & (state_q == UpdateDr);
    assign dmi_clear_o    = dmi_clear_q;
    assign dmi_select_o   = (ir_q == IrDmiAccess);
    assign dtmcs_select_o = (ir_q == IrDtmcs);
    assign tdi_o          = tdi_s;
    assign tdo_o          = tdo_q;
    assign tdo_oe_o       = tdo_oe_q;

endmodule

// File: doc/dm_tap.md
Name: dm_tap

Overview:
- Single-clock JTAG TAP controller for the debug transport path. It sits directly upstream of the DTM block.
- Oversamples the external JTAG pins on the system clock and runs the IEEE 1149.1 16-state TAP FSM.
- Holds the instruction register, IDCODE and BYPASS registers.
- Produces the capture/shift/update strobes, the DR select lines and the tdi bit that the DTM shift logic consumes. Muxes TDO back to the pin.

Parameters:
IrLength, 5, instruction register width in bits
IdcodeValue, 32'h00000001, value captured by IDCODE (bit 0 must be 1)
SyncStages, 2, flops in each pin synchronizer (minimum 2)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
tck_i  input  1  JTAG TCK pin, asynchronous to clk
tms_i  input  1  JTAG TMS pin
tdi_i  input  1  JTAG TDI pin
trst_i  input  1  JTAG TRST pin, active-low, synchronized then applied synchronously
dmi_tdo_i  input  1  DR serial-out bit from the DTM DMI register (dr_q[0])
dtmcs_tdo_i  input  1  DR serial-out bit from the DTM dtmcs register
tdo_o  output  1  JTAG TDO pin
tdo_oe_o  output  1  TDO output enable
tdi_o  output  1  synchronized TDI, valid while shift_o=1
capture_o  output  1  one-clk strobe: CaptureDr advanced on a tck rise
shift_o  output  1  one-clk strobe: ShiftDr advanced on a tck rise
update_o  output  1  one-clk strobe: UpdateDr advanced on a tck rise
dmi_select_o  output  1  IR == DMIACCESS
dtmcs_select_o  output  1  IR == DTMCS
dmi_clear_o  output  1  one-clk strobe on entry to TestLogicReset

Behaviour:
Pin synchronization:
- tck, tms, tdi and trst each pass through a SyncStages-flop synchronizer.
- tck_rise = sync_tck & ~tck_prev; tck_fall = ~sync_tck & tck_prev.
- Pin-edge to internal-action latency is SyncStages+1 clk.
- Each tck high phase and each tck low phase must last at least SyncStages+2 clk periods. Faster tck is unsupported.

TAP FSM:
- States: TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr, UpdateDr, SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr.
- Advances only on tck_rise, using synchronized TMS; standard 1149.1 transitions.
- SelectIrScan with TMS=1 goes to TestLogicReset.
- Five consecutive TMS=1 rises reach TestLogicReset from any state.

Strobes:
- capture_o, shift_o and update_o assert for exactly the clk cycle of the tck_rise, decoded from the state before the transition.
- No strobe is produced in Pause or Exit states.

Instruction register:
- Encodings: BYPASS0=0x00, IDCODE=0x01, DTMCS=0x10, DMIACCESS=0x11, BYPASS1=0x1F. Any other value selects BYPASS.
- CaptureIr loads the IR shift register with 5'b00101.
- ShiftIr shifts right, with TDI entering the MSB.
- UpdateIr copies the shift register into the IR.
- IR resets to IDCODE.
- dmi_select_o and dtmcs_select_o are decoded from the IR; they are never both 1.

Data registers:
- IDCODE: CaptureDr with IR=IDCODE loads IdcodeValue; ShiftDr shifts right.
- BYPASS: a 1-bit register cleared in CaptureDr and loaded from TDI in ShiftDr.
- DTMCS and DMIACCESS data registers live in the DTM; this block only supplies the strobes, tdi_o and the select lines.

TDO:
- Registered on tck_fall.
- In ShiftIr: tdo_o = IR shift register bit 0.
- In ShiftDr: tdo_o = IDCODE bit 0, bypass bit, dtmcs_tdo_i or dmi_tdo_i, selected by the IR.
- tdo_oe_o = 1 only when the state at that fall is ShiftIr or ShiftDr; otherwise tdo_oe_o=0 and tdo_o=0.

Reset:
- reset=0 or synchronized trst=0 forces: state=TestLogicReset, IR=IDCODE, shift registers cleared, tdo_o=0, tdo_oe_o=0.
- All strobes are 0 during reset. dmi_clear_o pulses once on the first clk cycle after reset or trst deasserts.
- trst takes priority over a simultaneous tck_rise.
- Asserting reset mid-scan aborts the scan; no update_o is produced.

dmi_clear_o:
- One-clk pulse on every FSM transition into TestLogicReset from another state.

Test Plan:
1. Release reset, then TMS 0,1,0,0 (into ShiftDr) and shift 32 bits with TMS=1 on the last → tdo_o yields 0x00000001 LSB-first; shift_o pulses 32 times, capture_o once; tdo_oe_o=1 only in ShiftDr.
2. Shift IR=0x11 and pass UpdateIr → first 5 TDO bits are 1,0,1,0,0; dmi_select_o=1 and dtmcs_select_o=0 afterwards.
3. With IR=DMIACCESS, run a 41-bit DR scan with dmi_tdo_i driven → exactly 1 capture_o, 41 shift_o and 1 update_o; tdo_o mirrors dmi_tdo_i; tdi_o matches the driven TDI on each shift_o.
4. IR=0x1F, shift TDI pattern 1,0,1,1 → tdo_o gives 0,1,0,1 (one-bit delay).
5. From ShiftDr apply 5 TMS=1 rises → state TestLogicReset, IR=0x01, exactly one dmi_clear_o pulse, selects=0.
6. Assert trst_i=0 mid-ShiftIr, coincident with a tck rise → TestLogicReset within SyncStages+1 clk; tdo_oe_o=0; no update_o; IR=IDCODE.
